// File: rtl/svc_rv_sram_arb.sv
// Round-robin arbiter sharing one synchronous-read SRAM between instruction fetch
// and data load/store, with one-cycle response routing and a contention counter.
module svc_rv_sram_arb #(
    parameter int AW    = 10,
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               i_req_valid,
    output logic               i_req_ready,
    input  logic [AW-1:0]      i_req_addr,
    output logic               i_rsp_valid,
    output logic [DW-1:0]      i_rsp_data,

    input  logic               d_req_valid,
    output logic               d_req_ready,
    input  logic [AW-1:0]      d_req_addr,
    input  logic               d_req_we,
    input  logic [DW-1:0]      d_req_wdata,
    input  logic [DW/8-1:0]    d_req_wstrb,
    output logic               d_rsp_valid,
    output logic [DW-1:0]      d_rsp_data,

    output logic               sram_en,
    output logic [AW-1:0]      sram_addr,
    output logic               sram_we,
    output logic [DW-1:0]      sram_wdata,
    output logic [DW/8-1:0]    sram_wstrb,
    input  logic [DW-1:0]      sram_rdata,

    output logic [CNT_W-1:0]   contention_cnt
);

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_e;

    req_e       prio;
    logic [1:0] rsp_dst;
    logic       gnt_i;
    logic       gnt_d;
    logic       both_valid;

    assign both_valid = i_req_valid && d_req_valid;

    // NOTE: grants are gated by rst so nothing reaches the SRAM while reset is applied.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (!rst) begin
            if (both_valid) begin
                gnt_d = (prio == REQ_D);
                gnt_i = (prio == REQ_I);
            end else begin
                gnt_i = i_req_valid;
                gnt_d = d_req_valid;
            end
        end
    end

    assign i_req_ready = gnt_i;
    assign d_req_ready = gnt_d;

    assign sram_en    = gnt_i || gnt_d;
    assign sram_addr  = gnt_d ? d_req_addr : i_req_addr;
    assign sram_we    = gnt_d && d_req_we;
    assign sram_wdata = d_req_wdata;
    assign sram_wstrb = sram_we ? d_req_wstrb : '0;

    // A read accepted just before reset must not surface while rst is high.
    assign i_rsp_valid = rsp_dst[0] && !rst;
    assign d_rsp_valid = rsp_dst[1] && !rst;
    assign i_rsp_data  = sram_rdata;
    assign d_rsp_data  = sram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio           <= REQ_D;
            rsp_dst        <= 2'b00;
            contention_cnt <= '0;
        end else begin
            if (gnt_i) begin
                prio <= REQ_D;
            end else if (gnt_d) begin
                prio <= REQ_I;
            end
            rsp_dst <= {gnt_d && !d_req_we, gnt_i};
            if (both_valid && (contention_cnt != {CNT_W{1'b1}})) begin
                contention_cnt <= contention_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_svc_rv_sram_arb.sv
// Directed bench for svc_rv_sram_arb: SRAM model, hand-computed expectations,
// plus a 4-bit counter instance sharing the same requests to check saturation.
module tb_svc_rv_sram_arb;

    logic        clk;
    logic        rst;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [9:0]  i_req_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [9:0]  d_req_addr;
    logic        d_req_we;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        sram_en;
    logic [9:0]  sram_addr;
    logic        sram_we;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_rdata;
    logic [31:0] contention_cnt;

    logic        s_i_req_ready, s_i_rsp_valid, s_d_req_ready, s_d_rsp_valid;
    logic [31:0] s_i_rsp_data, s_d_rsp_data, s_sram_wdata;
    logic        s_sram_en, s_sram_we;
    logic [9:0]  s_sram_addr;
    logic [3:0]  s_sram_wstrb;
    logic [31:0] s_sram_rdata;
    logic [3:0]  s_contention_cnt;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    svc_rv_sram_arb #(.AW(10), .DW(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .sram_en(sram_en), .sram_addr(sram_addr), .sram_we(sram_we),
        .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb), .sram_rdata(sram_rdata),
        .contention_cnt(contention_cnt)
    );

    svc_rv_sram_arb #(.AW(10), .DW(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(s_i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(s_i_rsp_valid), .i_rsp_data(s_i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(s_d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
        .d_rsp_valid(s_d_rsp_valid), .d_rsp_data(s_d_rsp_data),
        .sram_en(s_sram_en), .sram_addr(s_sram_addr), .sram_we(s_sram_we),
        .sram_wdata(s_sram_wdata), .sram_wstrb(s_sram_wstrb), .sram_rdata(s_sram_rdata),
        .contention_cnt(s_contention_cnt)
    );

    assign s_sram_rdata = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte-enabled, synchronous-read SRAM model.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wstrb[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [9:0] ia, input logic dv,
                         input logic dwe, input logic [9:0] da,
                         input logic [31:0] wd, input logic [3:0] ws);
        i_req_valid = iv;
        i_req_addr  = ia;
        d_req_valid = dv;
        d_req_we    = dwe;
        d_req_addr  = da;
        d_req_wdata = wd;
        d_req_wstrb = ws;
    endtask

    task automatic idle();
        drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        mem[1] = 32'h1111_0001;
        mem[2] = 32'h2222_0002;
        mem[3] = 32'h3333_0003;
        sram_rdata = 32'h0;

        // Reset with both requesters active: nothing may be granted.
        rst = 1'b1;
        drive(1'b1, 10'd1, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF, 4'hF);
        cyc();
        sample();
        check("rst_i_ready", i_req_ready, 0);
        check("rst_d_ready", d_req_ready, 0);
        check("rst_sram_en", sram_en, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_i_rsp", i_rsp_valid, 0);
        check("rst_d_rsp", d_rsp_valid, 0);
        check("rst_cnt", contention_cnt, 0);
        cyc();
        rst = 1'b0;

        // Write then read back.
        drive(1'b0, 10'd0, 1'b1, 1'b1, 10'd5, 32'hC594_BFC3, 4'hF);
        sample();
        check("wr_d_ready", d_req_ready, 1);
        check("wr_sram_en", sram_en, 1);
        check("wr_sram_we", sram_we, 1);
        check("wr_sram_addr", sram_addr, 5);
        check("wr_sram_wdata", sram_wdata, 32'hC594_BFC3);
        check("wr_sram_wstrb", sram_wstrb, 4'hF);
        cyc();
        drive(1'b0, 10'd0, 1'b1, 1'b0, 10'd5, 32'hFFFF_FFFF, 4'hF);
        sample();
        check("rd_sram_we", sram_we, 0);
        check("rd_sram_wstrb", sram_wstrb, 0);
        check("wr_no_rsp", d_rsp_valid, 0);
        cyc();
        idle();
        sample();
        check("rd_d_rsp_valid", d_rsp_valid, 1);
        check("rd_d_rsp_data", d_rsp_data, 32'hC594_BFC3);
        check("rd_i_rsp_quiet", i_rsp_valid, 0);
        check("idle_sram_en", sram_en, 0);
        cyc();
        check("rd_rsp_one_cycle", d_rsp_valid, 0);

        // Byte strobes, including an all-zero strobe write.
        drive(1'b0, 10'd0, 1'b1, 1'b1, 10'd7, 32'h8B29_7F86, 4'hF);
        cyc();
        drive(1'b0, 10'd0, 1'b1, 1'b1, 10'd7, 32'h0000_00AA, 4'h1);
        cyc();
        drive(1'b0, 10'd0, 1'b1, 1'b1, 10'd7, 32'hFFFF_FFFF, 4'h0);
        sample();
        check("zstrb_d_ready", d_req_ready, 1);
        check("zstrb_sram_we", sram_we, 1);
        check("zstrb_wstrb", sram_wstrb, 0);
        cyc();
        drive(1'b0, 10'd0, 1'b1, 1'b0, 10'd7, 32'h0, 4'h0);
        cyc();
        idle();
        sample();
        check("strb_rsp_valid", d_rsp_valid, 1);
        check("strb_rsp_data", d_rsp_data, 32'h8B29_7FAA);
        cyc();

        // Idle cycle keeps prio (fetch preferred after the data grants).
        drive(1'b1, 10'd3, 1'b1, 1'b0, 10'd2, 32'h0, 4'h0);
        sample();
        check("hold_prio_i_ready", i_req_ready, 1);
        check("hold_prio_d_ready", d_req_ready, 0);
        check("hold_prio_addr", sram_addr, 3);
        cyc();
        drive(1'b0, 10'd0, 1'b1, 1'b0, 10'd2, 32'h0, 4'h0);
        sample();
        check("lone_d_ready", d_req_ready, 1);
        check("lone_d_addr", sram_addr, 2);
        check("pipe_i_rsp_valid", i_rsp_valid, 1);
        check("pipe_i_rsp_data", i_rsp_data, 32'h3333_0003);
        cyc();
        idle();
        sample();
        check("pipe_d_rsp_data", d_rsp_data, 32'h2222_0002);
        check("pipe_d_rsp_valid", d_rsp_valid, 1);
        check("cnt_one", contention_cnt, 1);
        cyc();
        drive(1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        sample();
        check("gap_i_ready", i_req_ready, 1);
        check("gap_sram_addr", sram_addr, 1);
        cyc();
        drive(1'b0, 10'd0, 1'b1, 1'b1, 10'd9, 32'h1234_5678, 4'hF);
        sample();
        check("gap_i_rsp_data", i_rsp_data, 32'h1111_0001);
        check("gap_i_rsp_valid", i_rsp_valid, 1);
        cyc();

        // Contention after reset: D, I, D, I.
        rst = 1'b1;
        idle();
        cyc();
        rst = 1'b0;
        drive(1'b1, 10'd1, 1'b1, 1'b0, 10'd2, 32'h0, 4'h0);
        sample();
        check("c0_d_ready", d_req_ready, 1);
        check("c0_i_ready", i_req_ready, 0);
        check("c0_addr", sram_addr, 2);
        cyc();
        sample();
        check("c1_i_ready", i_req_ready, 1);
        check("c1_addr", sram_addr, 1);
        check("c1_d_rsp_valid", d_rsp_valid, 1);
        check("c1_d_rsp_data", d_rsp_data, 32'h2222_0002);
        check("c1_i_rsp_quiet", i_rsp_valid, 0);
        cyc();
        sample();
        check("c2_d_ready", d_req_ready, 1);
        check("c2_i_rsp_valid", i_rsp_valid, 1);
        check("c2_i_rsp_data", i_rsp_data, 32'h1111_0001);
        cyc();
        sample();
        check("c3_i_ready", i_req_ready, 1);
        check("c3_d_rsp_valid", d_rsp_valid, 1);
        cyc();
        idle();
        sample();
        check("c4_i_rsp_valid", i_rsp_valid, 1);
        check("c4_i_rsp_data", i_rsp_data, 32'h1111_0001);
        check("c4_d_rsp_quiet", d_rsp_valid, 0);
        check("c4_cnt", contention_cnt, 4);
        check("c4_cnt_small", s_contention_cnt, 4);
        cyc();

        // Reset one cycle after an accepted fetch read.
        drive(1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'h0, 4'h0);
        sample();
        check("rm_i_ready", i_req_ready, 1);
        cyc();
        rst = 1'b1;
        drive(1'b1, 10'd1, 1'b1, 1'b0, 10'd2, 32'h0, 4'h0);
        sample();
        check("rm_n1_i_rsp", i_rsp_valid, 0);
        check("rm_n1_sram_en", sram_en, 0);
        check("rm_n1_d_ready", d_req_ready, 0);
        cyc();
        rst = 1'b0;
        idle();
        sample();
        check("rm_n2_i_rsp", i_rsp_valid, 0);
        check("rm_cnt", contention_cnt, 0);
        check("rm_cnt_small", s_contention_cnt, 0);
        cyc();

        // 20 contended cycles: alternating grants, data first, 4-bit counter saturates.
        drive(1'b1, 10'd1, 1'b1, 1'b0, 10'd2, 32'h0, 4'h0);
        for (int k = 0; k < 20; k++) begin
            sample();
            check("sat_d_ready", d_req_ready, (k % 2 == 0) ? 1 : 0);
            check("sat_i_ready", i_req_ready, (k % 2 == 0) ? 0 : 1);
            cyc();
        end
        idle();
        sample();
        check("sat_cnt_small", s_contention_cnt, 15);
        check("sat_cnt", contention_cnt, 20);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
